// File: rtl/jtpopeye_dma.sv
// Per-frame object DMA: on each VB rising edge it takes the Z80 bus and copies LEN bytes
// of main RAM into object RAM. The read latency is tracked by a valid/address token pipeline.
module jtpopeye_dma #(
    parameter int AW     = 10,
    parameter int LEN    = 1024,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          VB,
    output logic          busrq_n,
    input  logic          busak_n,
    output logic          dma_cs,
    output logic [AW-1:0] AD_DMA,
    input  logic [7:0]    DD_DMA,
    output logic [AW-1:0] obj_addr,
    output logic [7:0]    obj_data,
    output logic          obj_we,
    output logic          busy,
    output logic          done,
    output logic          miss
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DRAIN} state_t;

    localparam logic [AW:0] LAST = (AW+1)'(LEN - 1);

    state_t        state_q;
    logic [AW:0]   cnt_q;
    logic          vbl_q;
    logic [RD_LAT:0] vld_q;
    logic [AW-1:0] addr_q [0:RD_LAT];

    logic start, issue, lost, pipe_empty, wr_d;

    assign start      = VB & ~vbl_q;
    assign issue      = (state_q == XFER) & cen & ~busak_n;
    assign lost       = ((state_q == XFER) | (state_q == DRAIN)) & busak_n;
    // Empty once the last token is leaving the pipeline on this clk
    assign pipe_empty = ~|vld_q[RD_LAT-1:0];
    assign wr_d       = vld_q[RD_LAT] & ~lost;

    // Stage 0 carries the address just put on AD_DMA; the last stage lines up with DD_DMA
    always_ff @(posedge clk) begin
        addr_q[0] <= cnt_q[AW-1:0];
        for (int k = 1; k <= RD_LAT; k++) begin
            addr_q[k] <= addr_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            vbl_q    <= 1'b0;
            vld_q    <= '0;
            busrq_n  <= 1'b1;
            dma_cs   <= 1'b0;
            AD_DMA   <= '0;
            obj_addr <= '0;
            obj_data <= '0;
            obj_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            miss     <= 1'b0;
        end else begin
            vbl_q  <= VB;
            done   <= 1'b0;
            miss   <= 1'b0;
            obj_we <= wr_d;
            if (wr_d) begin
                obj_addr <= addr_q[RD_LAT];
                obj_data <= DD_DMA;
            end
            vld_q <= lost ? '0 : {vld_q[RD_LAT-1:0], issue};

            case (state_q)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        busrq_n <= 1'b0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (!busak_n) begin
                        cnt_q   <= '0;
                        dma_cs  <= 1'b1;
                        state_q <= XFER;
                    end else if (!VB) begin
                        busrq_n <= 1'b1;
                        miss    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                XFER, DRAIN: begin
                    if (lost) begin
                        dma_cs  <= 1'b0;
                        busrq_n <= 1'b1;
                        miss    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end else if (state_q == XFER) begin
                        if (issue) begin
                            AD_DMA <= cnt_q[AW-1:0];
                            cnt_q  <= cnt_q + 1'b1;
                            if (cnt_q == LAST) state_q <= DRAIN;
                        end
                    end else if (pipe_empty) begin
                        // busy stays up one more clk and is cleared from IDLE
                        dma_cs  <= 1'b0;
                        busrq_n <= 1'b1;
                        done    <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Scoreboard bench for jtpopeye_dma: a full-size instance (LEN=1024) and a short one (LEN=16),
// each fed by a main-RAM model with registered address and registered data.
module tb_jtpopeye_dma;

    localparam int AW     = 10;
    localparam int LEN_A  = 1024;
    localparam int LEN_B  = 16;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cen, VB, busak_n, busrq_n, dma_cs, obj_we, busy, done, miss;
    logic [AW-1:0] AD_DMA, obj_addr;
    logic [7:0]    DD_DMA, obj_data;

    logic          cen_b, vb_b, busak_n_b, busrq_n_b, dma_cs_b, obj_we_b, busy_b, done_b, miss_b;
    logic [AW-1:0] ad_b, obj_addr_b;
    logic [7:0]    dd_b, obj_data_b;

    jtpopeye_dma #(.AW(AW), .LEN(LEN_A), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst(rst), .cen(cen), .VB(VB), .busrq_n(busrq_n), .busak_n(busak_n),
        .dma_cs(dma_cs), .AD_DMA(AD_DMA), .DD_DMA(DD_DMA), .obj_addr(obj_addr),
        .obj_data(obj_data), .obj_we(obj_we), .busy(busy), .done(done), .miss(miss)
    );

    jtpopeye_dma #(.AW(AW), .LEN(LEN_B), .RD_LAT(RD_LAT)) u_dut_b (
        .clk(clk), .rst(rst), .cen(cen_b), .VB(vb_b), .busrq_n(busrq_n_b), .busak_n(busak_n_b),
        .dma_cs(dma_cs_b), .AD_DMA(ad_b), .DD_DMA(dd_b), .obj_addr(obj_addr_b),
        .obj_data(obj_data_b), .obj_we(obj_we_b), .busy(busy_b), .done(done_b), .miss(miss_b)
    );

    // Main RAM: registered address then registered data, two clks of read latency
    logic [7:0]    mem [0:1023];
    logic [AW-1:0] ram_a, ram_b;
    always @(posedge clk) begin
        ram_a  <= AD_DMA;
        DD_DMA <= mem[ram_a];
        ram_b  <= ad_b;
        dd_b   <= mem[ram_b];
    end

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int we_a = 0, done_a = 0, miss_a = 0;
    int we_b = 0, done_b_cnt = 0, miss_b_cnt = 0;
    int c0_a = -1, rel_cyc_a = -1;
    logic prev_rq_a = 1'b1, prev_cs_b = 1'b0;
    logic [17:0] qa[$];
    logic [17:0] qb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clk: sample both DUTs at the falling edge and score any writes
    task automatic tick();
        logic [17:0] e;
        @(negedge clk);
        cyc++;
        if (obj_we) begin
            we_a++;
            if (qa.size() == 0) chk("we_unexp_a", {31'd0, obj_we}, 32'd0);
            else begin
                e = qa.pop_front();
                chk("we_addr_a", {22'd0, obj_addr}, {22'd0, e[17:8]});
                chk("we_data_a", {24'd0, obj_data}, {24'd0, e[7:0]});
            end
        end
        if (done) done_a++;
        if (miss) miss_a++;
        if (done | miss) chk("done_miss_a", {31'd0, done & miss}, 32'd0);
        if (!prev_rq_a && busrq_n) rel_cyc_a = cyc;
        prev_rq_a = busrq_n;
        if (dma_cs && c0_a < 0) c0_a = cyc;
        if (obj_we_b) begin
            we_b++;
            chk("cs_hold_b", {31'd0, prev_cs_b}, 32'd1);
            if (qb.size() == 0) chk("we_unexp_b", {31'd0, obj_we_b}, 32'd0);
            else begin
                e = qb.pop_front();
                chk("we_addr_b", {22'd0, obj_addr_b}, {22'd0, e[17:8]});
                chk("we_data_b", {24'd0, obj_data_b}, {24'd0, e[7:0]});
            end
        end
        if (done_b) done_b_cnt++;
        if (miss_b) miss_b_cnt++;
        prev_cs_b = dma_cs_b;
    endtask

    task automatic push_a();
        for (int i = 0; i < LEN_A; i++) begin
            logic [9:0] a;
            a = 10'(i);
            qa.push_back({a, a[7:0] ^ 8'h5A});
        end
    endtask

    task automatic req_and_grant(input string tag);
        int n;
        VB = 1'b1;
        n = 0;
        while (busrq_n && n < 5) begin tick(); n++; end
        chk({tag, "_req"}, {31'd0, busrq_n}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        repeat (3) tick();
        busak_n = 1'b0;
    endtask

    task automatic normal_copy(input string tag, input bit retrig);
        int we0, d0, m0, n;
        bit rt;
        push_a();
        we0 = we_a; d0 = done_a; m0 = miss_a;
        c0_a = -1; rel_cyc_a = -1;
        req_and_grant(tag);
        rt = 1'b0;
        n = 0;
        while (done_a == d0 && n < 3000) begin
            tick();
            n++;
            if (retrig && !rt && dma_cs && AD_DMA == 10'd300) begin
                VB = 1'b0;
                tick();
                VB = 1'b1;
                rt = 1'b1;
            end
        end
        chk({tag, "_done"}, done_a - d0, 1);
        busak_n = 1'b1;
        VB = 1'b0;
        repeat (4) tick();
        chk({tag, "_we_cnt"}, we_a - we0, LEN_A);
        chk({tag, "_q_left"}, qa.size(), 0);
        chk({tag, "_done_cnt"}, done_a - d0, 1);
        chk({tag, "_miss_cnt"}, miss_a - m0, 0);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cs_end"}, {31'd0, dma_cs}, 32'd0);
        chk({tag, "_rq_end"}, {31'd0, busrq_n}, 32'd1);
        chk({tag, "_release_lat"},
            {31'd0, (c0_a >= 0) && (rel_cyc_a >= 0) && (rel_cyc_a - (c0_a + LEN_A) <= RD_LAT + 1)},
            32'd1);
        qa.delete();
    endtask

    initial begin
        int base_we, base_m, base_d, n, w1;
        bit found;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
        rst = 1'b1; cen = 1'b1; VB = 1'b0; busak_n = 1'b1;
        cen_b = 1'b0; vb_b = 1'b0; busak_n_b = 1'b1;
        repeat (3) tick();
        chk("rst_busrq_n", {31'd0, busrq_n}, 32'd1);
        chk("rst_dma_cs", {31'd0, dma_cs}, 32'd0);
        chk("rst_ad", {22'd0, AD_DMA}, 32'd0);
        chk("rst_obj_addr", {22'd0, obj_addr}, 32'd0);
        chk("rst_obj_data", {24'd0, obj_data}, 32'd0);
        chk("rst_obj_we", {31'd0, obj_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_miss", {31'd0, miss}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        normal_copy("norm", 1'b0);

        // Short transfer with cen only every 4th clk
        for (int i = 0; i < LEN_B; i++) begin
            logic [9:0] a;
            a = 10'(i);
            qb.push_back({a, a[7:0] ^ 8'h5A});
        end
        base_we = we_b; base_d = done_b_cnt; base_m = miss_b_cnt;
        vb_b = 1'b1;
        n = 0; w1 = 0;
        while (done_b_cnt == base_d && n < 400) begin
            tick();
            n++;
            cen_b = (cyc % 4 == 0);
            if (!busrq_n_b && busak_n_b) begin
                w1++;
                if (w1 == 3) busak_n_b = 1'b0;
            end
        end
        chk("sparse_done", done_b_cnt - base_d, 1);
        chk("sparse_we_cnt", we_b - base_we, LEN_B);
        chk("sparse_q_left", qb.size(), 0);
        chk("sparse_miss", miss_b_cnt - base_m, 0);
        tick();
        chk("sparse_cs_end", {31'd0, dma_cs_b}, 32'd0);
        busak_n_b = 1'b1; vb_b = 1'b0; cen_b = 1'b0;
        repeat (2) tick();
        chk("sparse_busy_end", {31'd0, busy_b}, 32'd0);

        // No grant: VB high for 100 clks, bus never acknowledged
        base_we = we_a; base_m = miss_a; base_d = done_a;
        VB = 1'b1;
        repeat (100) tick();
        chk("nogrant_rq_held", {31'd0, busrq_n}, 32'd0);
        VB = 1'b0;
        repeat (3) tick();
        chk("nogrant_rq_rel", {31'd0, busrq_n}, 32'd1);
        chk("nogrant_miss", miss_a - base_m, 1);
        chk("nogrant_we", we_a - base_we, 0);
        chk("nogrant_done", done_a - base_d, 0);
        chk("nogrant_busy", {31'd0, busy}, 32'd0);

        // Bus taken away after 10 addresses
        push_a();
        base_we = we_a; base_m = miss_a; base_d = done_a;
        req_and_grant("lost");
        found = 1'b0; n = 0;
        while (!found && n < 100) begin
            tick();
            n++;
            if (dma_cs && AD_DMA == 10'd9) begin
                busak_n = 1'b1;
                found = 1'b1;
            end
        end
        chk("lost_reach9", {31'd0, found}, 32'd1);
        tick();
        w1 = we_a;
        repeat (5) tick();
        chk("lost_no_late_we", we_a, w1);
        chk("lost_we_le10", {31'd0, (we_a - base_we) <= 10}, 32'd1);
        chk("lost_miss", miss_a - base_m, 1);
        chk("lost_done", done_a - base_d, 0);
        chk("lost_busy", {31'd0, busy}, 32'd0);
        chk("lost_rq", {31'd0, busrq_n}, 32'd1);
        chk("lost_cs", {31'd0, dma_cs}, 32'd0);
        qa.delete();
        VB = 1'b0;
        repeat (2) tick();

        // Reset asserted while address 500 is on the bus
        push_a();
        req_and_grant("rstx");
        found = 1'b0; n = 0;
        while (!found && n < 1000) begin
            tick();
            n++;
            if (dma_cs && AD_DMA == 10'd500) found = 1'b1;
        end
        chk("rstx_reach500", {31'd0, found}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstx_rq", {31'd0, busrq_n}, 32'd1);
        chk("rstx_cs", {31'd0, dma_cs}, 32'd0);
        chk("rstx_we", {31'd0, obj_we}, 32'd0);
        chk("rstx_busy", {31'd0, busy}, 32'd0);
        qa.delete();
        tick();
        rst = 1'b0; VB = 1'b0; busak_n = 1'b1;
        repeat (2) tick();
        normal_copy("post_rst", 1'b0);

        // Second VB rise mid-transfer must be ignored
        normal_copy("retrig", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/jtpopeye_dma.md
Name: jtpopeye_dma

Overview:
- Sprite/object DMA engine that sits directly downstream of the main CPU block.
- Once per frame, at the rising edge of VB, it requests the Z80 bus and copies LEN bytes of main work RAM (main-RAM window 0x8C00–0x8FFF, accessed through the DMA read port AD_DMA/DD_DMA with dma_cs) into the object line buffer RAM. It then releases the bus.
- It owns the busrq_n/dma_cs/AD_DMA signals that the main CPU block consumes.

Parameters:
- AW, 10, DMA address width; the source offset is AD_DMA[AW-1:0].
- LEN, 1024, number of bytes copied per transfer, 1..2^AW.
- RD_LAT, 2, clk cycles from AD_DMA/dma_cs being presented to DD_DMA being valid (registered address plus registered RAM output).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- cen, in, 1, issue enable; one source address is issued per cen cycle.
- VB, in, 1, vertical blank from video timing.
- busrq_n, out, 1, Z80 bus request, active low.
- busak_n, in, 1, Z80 bus acknowledge, active low.
- dma_cs, out, 1, selects DMA access to main RAM.
- AD_DMA, out, AW, source offset into main RAM.
- DD_DMA, in, 8, data read from main RAM.
- obj_addr, out, AW, destination address into object RAM.
- obj_data, out, 8, data to object RAM.
- obj_we, out, 1, object RAM write strobe, one clk per byte.
- busy, out, 1, high from request until bus release.
- done, out, 1, one-clk pulse when a transfer completes normally.
- miss, out, 1, one-clk pulse when a transfer is aborted.

Behaviour:
- Reset values: busrq_n=1, dma_cs=0, AD_DMA=0, obj_addr=0, obj_data=0, obj_we=0, busy=0, done=0, miss=0. The internal pipeline valid bits are cleared. Reset asserted mid-transfer releases the bus immediately, and the partial copy is left as-is.
- VB rising edge detection: VBl is sampled every clk, not gated by cen; start = VB & ~VBl.
- IDLE:
  - On start, go to REQ.
  - In the same clk set busrq_n=0 and busy=1.
- REQ:
  - Wait for busak_n=0; then clear the counter to 0 and go to XFER.
  - If VB falls before the grant: busrq_n=1, miss pulses, go to IDLE.
- XFER:
  - dma_cs=1. On each clk with cen=1, AD_DMA takes the counter value and the counter increments.
  - A valid token carrying that address enters an RD_LAT-deep shift pipeline, which advances every clk.
  - After issuing address LEN-1, go to DRAIN.
- DRAIN:
  - dma_cs stays 1 until the pipeline is empty. Then dma_cs=0 and busrq_n=1, done pulses, and busy falls one clk later. Go to IDLE.
- Write path:
  - When a token exits the pipeline: obj_we=1, obj_data=DD_DMA, obj_addr=the token's address, all for exactly one clk.
  - Each source address produces exactly one write, in ascending order.
- busak_n rising during XFER or DRAIN (bus taken away):
  - dma_cs=0 and the pipeline is flushed, so no further obj_we.
  - busrq_n=1, miss pulses, go to IDLE.
- start outside IDLE is ignored; no retrigger.
- Counter width is AW+1 so that LEN=2^AW terminates correctly; AD_DMA wraps naturally.
- If cen is stuck at 0 in XFER, hold: no address advance and no writes. This is not a fault.
- done and miss never pulse in the same clk.

Test Plan:
- Normal copy: preload RAM[i]=i^8'h5A; cen=1 always; VB rises; busak_n granted 3 clks after busrq_n=0 -> 1024 obj_we pulses with obj_addr 0..1023 and obj_data=i^5A; done pulses once; busrq_n=1 within RD_LAT+1 clks of the last issue.
- Sparse cen (cen every 4th clk), LEN=16 -> exactly 16 writes, addresses 0..15 in order, no duplicates; dma_cs remains 1 until the last write.
- No grant: busak_n held 1, VB pulses high for 100 clks -> busrq_n returns to 1 on the VB fall, miss pulses once, zero obj_we.
- Bus lost: busak_n deasserted after 10 addresses issued -> at most 10 writes, no writes after the following clk, miss=1 pulse, busy=0.
- Reset mid-XFER at address 500: rst=1 -> busrq_n=1, dma_cs=0, obj_we=0 in the same cycle. After release, the next VB rise performs a full 0..1023 copy.
- Second VB rise during XFER -> ignored; exactly one done and 1024 writes total.
